// File: rtl/mod_up_down_counter_if.sv
// Control/status bundle for mod_up_down_counter: enable, direction, load strobe
// and value in; registered count, wrap pulse and bound flags out.
interface mod_up_down_counter_if #(
    parameter int WIDTH = 4
);
    logic             i_en;
    logic             i_mode;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic [WIDTH-1:0] o_data_out;
    logic             o_wrap;
    logic             o_at_max;
    logic             o_at_min;

    modport master (
        output i_en, i_mode, i_load, i_load_val,
        input  o_data_out, o_wrap, o_at_max, o_at_min
    );

    modport slave (
        input  i_en, i_mode, i_load, i_load_val,
        output o_data_out, o_wrap, o_at_max, o_at_min
    );
endinterface

// File: rtl/mod_up_down_counter.sv
// Modulo-N up/down counter (0..MAX_COUNT) with enable, clamped parallel load, wrap pulse
// and bound flags. Define UDC_SATURATE_EN to saturate at the bounds instead of wrapping.
module mod_up_down_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 8,
    parameter int RESET_VAL = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    mod_up_down_counter_if.slave  bus
);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;

    // One spare bit keeps +1 at 2**WIDTH-1 and -1 at 0 visible to the range check.
    assign w_cnt_ext  = {1'b0, r_count};
    assign w_load_ext = {1'b0, bus.i_load_val};
    assign w_inc      = w_cnt_ext + 1'b1;
    assign w_dec      = w_cnt_ext - 1'b1;

    always_comb begin
        w_next      = r_count;
        w_wrap_next = 1'b0;
        if (bus.i_load) begin
            w_next = (w_load_ext > MAX_EXT) ? MAX_VAL : bus.i_load_val;
        end else if (bus.i_en) begin
            if (bus.i_mode) begin
                if (w_inc > MAX_EXT) begin
                    w_wrap_next = 1'b1;
`ifdef UDC_SATURATE_EN
                    w_next      = MAX_VAL;
`else
                    w_next      = '0;
`endif
                end else begin
                    w_next = w_inc[WIDTH-1:0];
                end
            end else begin
                if (w_dec[WIDTH]) begin
                    w_wrap_next = 1'b1;
`ifdef UDC_SATURATE_EN
                    w_next      = '0;
`else
                    w_next      = MAX_VAL;
`endif
                end else begin
                    w_next = w_dec[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= RST_VAL;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign bus.o_data_out = r_count;
    assign bus.o_wrap     = r_wrap;
    assign bus.o_at_max   = (r_count == MAX_VAL);
    assign bus.o_at_min   = (r_count == '0);
endmodule
